// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-flop input synchronizer and registered pulse outputs.
// Defining UART_RX_PARITY_EN adds a parity bit (sense set by PARITY_ODD) and enables parity_err.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME       = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_done_tick,
    output logic                  frame_err,
    output logic                  parity_err
);
    localparam int TW = $clog2(TIME);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(TIME / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIME - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_bad;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    assign parity_err = 1'b0;
`endif

    state_t                state;
    logic                  rx_m, rx_s, rx_prev;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    // rx_prev gates the start edge so a held-low line (break) cannot re-trigger
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_cnt == T_HALF) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            par_bad  <= ((^shreg) ^ rx_s) != PARITY_ODD[0];
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                dout         <= shreg;
                                rx_done_tick <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames; expected pulses are queued by stimulus and popped by a monitor.
module tb_uart_rx;
    localparam int TIME = 16;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick, frame_err, parity_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   tick_div = 1;
    int   tick_phase = 0;

    localparam logic [2:0] K_DONE = 3'b100;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_PERR = 3'b001;

    uart_rx #(.DATA_WIDTH(8), .TIME(TIME), .PARITY_ODD(0)) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .rx(rx),
        .dout(dout),
        .rx_done_tick(rx_done_tick),
        .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_phase = (tick_phase + 1) % tick_div;
        s_tick = (tick_phase == 0);
    end

    always @(negedge clk) begin
        if (reset && (rx_done_tick || frame_err || parity_err)) begin
            exp_t e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse got={done,ferr,perr}=%b dout=%h required=none", {rx_done_tick, frame_err, parity_err}, dout);
            end else begin
                e = exp_q.pop_front();
                if ({rx_done_tick, frame_err, parity_err} != e.kind) begin
                    failures++;
                    $display("FAIL pulse_kind got=%b required=%b", {rx_done_tick, frame_err, parity_err}, e.kind);
                end
                checks++;
                if (dout != e.data) begin
                    failures++;
                    $display("FAIL pulse_dout got=%h required=%h", dout, e.data);
                end
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (TIME * tick_div) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic use_par, input logic par);
        if (use_par) send_bits({5'b0, stop_bit, par, d, 1'b0}, 11);
        else send_bits({6'b0, stop_bit, d, 1'b0}, 10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(200);
        check8("reset_dout", dout, 8'h00);
        check8("reset_no_pulses", 8'(pulses), 8'd0);

        exp_q.push_back('{K_DONE, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(20);
        check8("dout_a5", dout, 8'hA5);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check8("glitch_no_pulse", 8'(pulses), 8'd1);
        exp_q.push_back('{K_DONE, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);

        exp_q.push_back('{K_FERR, 8'h3C});
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (3 * TIME) @(negedge clk);
        check8("break_pulses", 8'(pulses), 8'd3);
        idle(32);
        check8("break_dout_kept", dout, 8'h3C);

        rx = 1'b0;
        repeat (TIME) @(negedge clk);
        send_bits(16'h0005, 3);
        rx = 1'b0;
        repeat (TIME / 2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check8("midframe_reset_dout", dout, 8'h00);
        reset = 1'b1;
        idle(40);
        check8("midframe_no_pulse", 8'(pulses), 8'd3);
        exp_q.push_back('{K_DONE, 8'h81});
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(20);

        tick_div = 2;
        idle(20);
        exp_q.push_back('{K_DONE, 8'h5A});
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{K_DONE, 8'hC3});
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        idle(40);
        tick_div = 1;
        idle(20);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{K_DONE, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        exp_q.push_back('{K_PERR, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        check8("parity_dout_kept", dout, 8'h07);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses got=%0d_outstanding required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
